coherent_bus_controller: RTL and testbench
==========================================

Name: coherent_bus_controller

Overview:
- Parametrised N-core memory/coherence controller between per-core I/D caches and a single-port RAM.
- Round-robin arbitration among cores for data transactions; instruction fetches serviced only when no data request pending.
- Snoops on read misses and write-intent transactions.
- Serves dirty blocks cache-to-cache with simultaneous RAM update; issues invalidates.
- Blocks are two words.

Parameters:
CPUS, 2, number of cores (>=2)
ADDR_W, 32, address width
DATA_W, 32, data word width

Ports:
CLK  in  1  clock
nRST  in  1  reset, asynchronous, active-low
iREN  in  CPUS  instruction read request per core
iaddr  in  CPUS*ADDR_W  instruction address per core
iwait  out  CPUS  instruction wait (0 = word complete this cycle)
iload  out  CPUS*DATA_W  instruction data per core
dREN  in  CPUS  data block read request (miss)
dWEN  in  CPUS  data block writeback request
daddr  in  CPUS*ADDR_W  data word address (cache sequences word0, word1)
dstore  in  CPUS*DATA_W  data to write / data supplied when snooped dirty
dwait  out  CPUS  data wait (0 = word complete this cycle)
dload  out  CPUS*DATA_W  data returned per core
cctrans  in  CPUS  coherence transaction request (miss or S->M upgrade)
ccwrite  in  CPUS  requester: write intent; snooped core: block dirty
ccwait  out  CPUS  core is being snooped, must answer
ccinv  out  CPUS  invalidate snooped block
ccsnoopaddr  out  CPUS*ADDR_W  snoop address broadcast
ramREN  out  1  RAM read
ramWEN  out  1  RAM write
ramaddr  out  ADDR_W  RAM address
ramstore  out  DATA_W  RAM write data
ramload  in  DATA_W  RAM read data
ramstate  in  2  FREE=0, BUSY=1, ACCESS=2, ERROR=3

Behaviour:
- States: IDLE, SNOOP, RREAD0, RREAD1, C2C0, C2C1, WB0, WB1, IFETCH. Registers: state, dgnt, igrant, drr, irr, snooper.
- Reset: state=IDLE; drr=irr=CPUS-1 (core 0 first); all iwait/dwait=1; ccwait, ccinv, ramREN, ramWEN, ramaddr, ramstore, ccsnoopaddr=0. dload/iload are combinational from ramload or snooper dstore.
- Data request[k] = dREN|dWEN|cctrans. IDLE grants first k with request set, searching drr+1, drr+2, ... mod CPUS; registers dgnt=k.
  - dWEN[k] -> WB0.
  - Otherwise -> SNOOP.
  - No data request and any iREN -> IFETCH; igrant chosen the same way from irr.
  - Data always wins over instruction.
- SNOOP, 1 cycle:
  - ccwait=1 and ccsnoopaddr=daddr[dgnt] for every core except dgnt.
  - ccinv=1 on the same cores if ccwrite[dgnt].
  - Next state:
    - Any non-requester ccwrite=1 -> C2C0, lowest index latched as snooper.
    - Else dREN[dgnt] -> RREAD0.
    - Else (upgrade only) -> IDLE, drr<=dgnt.
- RREAD0/1: ramREN=1, ramaddr=daddr[dgnt]. On ramstate==ACCESS: dwait[dgnt]=0, dload[dgnt]=ramload, advance. RREAD1 -> IDLE.
- C2C0/1:
  - ccwait[snooper] held, ramWEN=1, ramaddr=daddr[snooper], ramstore=dstore[snooper], dload[dgnt]=dstore[snooper].
  - On ACCESS: dwait[dgnt]=0 and dwait[snooper]=0 same cycle, advance. C2C1 -> IDLE.
- WB0/1: ramWEN=1, ramaddr=daddr[dgnt], ramstore=dstore[dgnt]; on ACCESS dwait[dgnt]=0, advance. WB1 -> IDLE.
- IFETCH: ramREN=1, ramaddr=iaddr[igrant]; on ACCESS iwait[igrant]=0, iload=ramload, -> IDLE, irr<=igrant.
- On every return to IDLE from a data state, drr<=dgnt.
- FREE/BUSY/ERROR: hold state, all waits stay 1, RAM strobes held. No timeout.
- Requester drops its enabling signal mid-transaction (dREN in RREAD*, dWEN in WB*): -> IDLE next cycle, no wait pulse, drr unchanged.
- Minimum latency per word: 1 cycle after ACCESS. No word completes in the same cycle the grant is made.
- Reset mid-operation: immediate return to reset values, partial block discarded.

Test Plan:
- Core0 dREN, daddr 0x100/0x104, no dirty snooper, RAM ACCESS after 2 BUSY cycles -> ccwait[1]=1 one cycle, then dwait[0]=0 twice with RAM data, ccinv=0.
- Core1 cctrans+ccwrite+dREN at 0x200, core0 answers ccwrite=1 with 0xDEADBEEF/0xCAFEF00D -> ccinv[0]=1, dload[1] equals those words, ramWEN=1 to 0x200/0x204, dwait[0] and dwait[1] low together.
- Both cores dWEN held continuously after reset -> grants alternate 0,1,0,1; each receives two dwait pulses per grant.
- Core0 iREN and core1 dREN same cycle -> data serviced first; iwait[0]=0 only after dREN block done.
- Core0 upgrade (cctrans, ccwrite, no dREN) -> ccinv[1]=1 for one cycle, no RAM strobe, IDLE next.
- nRST low during RREAD1 -> ramREN=0 and all waits=1 immediately; core1 wins first grant after release only if core0 idle.

Source files
------------

// File: rtl/coherent_bus_controller.sv
// N-core coherence/memory controller: round-robin data arbitration, snooping,
// cache-to-cache transfer of dirty blocks and instruction fetch on a single-port RAM.
module coherent_bus_controller #(
    parameter int CPUS   = 2,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                     CLK,
    input  logic                     nRST,
    input  logic [CPUS-1:0]          iREN,
    input  logic [CPUS*ADDR_W-1:0]   iaddr,
    output logic [CPUS-1:0]          iwait,
    output logic [CPUS*DATA_W-1:0]   iload,
    input  logic [CPUS-1:0]          dREN,
    input  logic [CPUS-1:0]          dWEN,
    input  logic [CPUS*ADDR_W-1:0]   daddr,
    input  logic [CPUS*DATA_W-1:0]   dstore,
    output logic [CPUS-1:0]          dwait,
    output logic [CPUS*DATA_W-1:0]   dload,
    input  logic [CPUS-1:0]          cctrans,
    input  logic [CPUS-1:0]          ccwrite,
    output logic [CPUS-1:0]          ccwait,
    output logic [CPUS-1:0]          ccinv,
    output logic [CPUS*ADDR_W-1:0]   ccsnoopaddr,
    output logic                     ramREN,
    output logic                     ramWEN,
    output logic [ADDR_W-1:0]        ramaddr,
    output logic [DATA_W-1:0]        ramstore,
    input  logic [DATA_W-1:0]        ramload,
    input  logic [1:0]               ramstate
);
    localparam int IDX_W = (CPUS > 1) ? $clog2(CPUS) : 1;

    typedef enum logic [3:0] {IDLE, SNOOP, RREAD0, RREAD1, C2C0, C2C1, WB0, WB1, IFETCH} state_t;

    state_t            state_r, next_state_s;
    logic [IDX_W-1:0]  dgnt_r, igrant_r, drr_r, irr_r, snooper_r;
    logic [IDX_W-1:0]  next_dgnt_s, next_igrant_s, next_drr_s, next_irr_s, next_snooper_s;
    logic [IDX_W-1:0]  dpick_s, ipick_s, dirty_idx_s;
    logic              dhit_s, ihit_s, dirty_any_s;
    logic [CPUS-1:0]   dreq_s;
    logic              access_s;
    logic              ramren_r, ramwen_r;
    logic [CPUS-1:0]   ccwait_r, ccinv_r;
    int                dk_s, ik_s;

    logic [ADDR_W-1:0] iaddr_a  [CPUS];
    logic [ADDR_W-1:0] daddr_a  [CPUS];
    logic [DATA_W-1:0] dstore_a [CPUS];

    function automatic logic [CPUS-1:0] onehot(input logic [IDX_W-1:0] idx);
        onehot = {{(CPUS-1){1'b0}}, 1'b1} << idx;
    endfunction

    genvar g;
    for (g = 0; g < CPUS; g++) begin : g_unpack
        assign iaddr_a[g]  = iaddr[g*ADDR_W +: ADDR_W];
        assign daddr_a[g]  = daddr[g*ADDR_W +: ADDR_W];
        assign dstore_a[g] = dstore[g*DATA_W +: DATA_W];
    end

    assign dreq_s   = dREN | dWEN | cctrans;
    assign access_s = (ramstate == 2'd2);
    assign ramREN   = ramren_r;
    assign ramWEN   = ramwen_r;
    assign ccwait   = ccwait_r;
    assign ccinv    = ccinv_r;

    // Round-robin pickers starting after the last grant, plus lowest-index dirty snooper.
    always_comb begin
        dhit_s      = 1'b0;
        ihit_s      = 1'b0;
        dpick_s     = drr_r;
        ipick_s     = irr_r;
        dirty_any_s = 1'b0;
        dirty_idx_s = '0;
        dk_s        = 0;
        ik_s        = 0;
        for (int i = 1; i <= CPUS; i++) begin
            dk_s = (int'(drr_r) + i) % CPUS;
            ik_s = (int'(irr_r) + i) % CPUS;
            if (!dhit_s && dreq_s[dk_s]) begin
                dhit_s  = 1'b1;
                dpick_s = IDX_W'(dk_s);
            end else begin
                dhit_s  = dhit_s;
            end
            if (!ihit_s && iREN[ik_s]) begin
                ihit_s  = 1'b1;
                ipick_s = IDX_W'(ik_s);
            end else begin
                ihit_s  = ihit_s;
            end
        end
        for (int i = CPUS - 1; i >= 0; i--) begin
            if (ccwrite[i] && (IDX_W'(i) != dgnt_r)) begin
                dirty_any_s = 1'b1;
                dirty_idx_s = IDX_W'(i);
            end else begin
                dirty_any_s = dirty_any_s;
            end
        end
    end

    // Next-state logic; a requester dropping its enable aborts without touching drr.
    always_comb begin
        next_state_s   = state_r;
        next_dgnt_s    = dgnt_r;
        next_igrant_s  = igrant_r;
        next_snooper_s = snooper_r;
        next_drr_s     = drr_r;
        next_irr_s     = irr_r;
        case (state_r)
            IDLE: begin
                if (dhit_s) begin
                    next_dgnt_s  = dpick_s;
                    next_state_s = dWEN[dpick_s] ? WB0 : SNOOP;
                end else if (ihit_s) begin
                    next_igrant_s = ipick_s;
                    next_state_s  = IFETCH;
                end else begin
                    next_state_s = IDLE;
                end
            end
            SNOOP: begin
                if (dirty_any_s) begin
                    next_snooper_s = dirty_idx_s;
                    next_state_s   = C2C0;
                end else if (dREN[dgnt_r]) begin
                    next_state_s = RREAD0;
                end else begin
                    next_state_s = IDLE;
                    next_drr_s   = dgnt_r;
                end
            end
            RREAD0: begin
                if (!dREN[dgnt_r])  next_state_s = IDLE;
                else if (access_s)  next_state_s = RREAD1;
                else                next_state_s = RREAD0;
            end
            RREAD1: begin
                if (!dREN[dgnt_r]) begin
                    next_state_s = IDLE;
                end else if (access_s) begin
                    next_state_s = IDLE;
                    next_drr_s   = dgnt_r;
                end else begin
                    next_state_s = RREAD1;
                end
            end
            C2C0: begin
                if (access_s) next_state_s = C2C1;
                else          next_state_s = C2C0;
            end
            C2C1: begin
                if (access_s) begin
                    next_state_s = IDLE;
                    next_drr_s   = dgnt_r;
                end else begin
                    next_state_s = C2C1;
                end
            end
            WB0: begin
                if (!dWEN[dgnt_r])  next_state_s = IDLE;
                else if (access_s)  next_state_s = WB1;
                else                next_state_s = WB0;
            end
            WB1: begin
                if (!dWEN[dgnt_r]) begin
                    next_state_s = IDLE;
                end else if (access_s) begin
                    next_state_s = IDLE;
                    next_drr_s   = dgnt_r;
                end else begin
                    next_state_s = WB1;
                end
            end
            IFETCH: begin
                if (!iREN[igrant_r]) begin
                    next_state_s = IDLE;
                end else if (access_s) begin
                    next_state_s = IDLE;
                    next_irr_s   = igrant_r;
                end else begin
                    next_state_s = IFETCH;
                end
            end
            default: next_state_s = IDLE;
        endcase
    end

    // State, grant registers and strobes registered from the upcoming state.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_r   <= IDLE;
            dgnt_r    <= '0;
            igrant_r  <= '0;
            snooper_r <= '0;
            drr_r     <= IDX_W'(CPUS - 1);
            irr_r     <= IDX_W'(CPUS - 1);
            ramren_r  <= 1'b0;
            ramwen_r  <= 1'b0;
            ccwait_r  <= '0;
            ccinv_r   <= '0;
        end else begin
            state_r   <= next_state_s;
            dgnt_r    <= next_dgnt_s;
            igrant_r  <= next_igrant_s;
            snooper_r <= next_snooper_s;
            drr_r     <= next_drr_s;
            irr_r     <= next_irr_s;
            ramren_r  <= (next_state_s == RREAD0) || (next_state_s == RREAD1) || (next_state_s == IFETCH);
            ramwen_r  <= (next_state_s == C2C0) || (next_state_s == C2C1) ||
                         (next_state_s == WB0)  || (next_state_s == WB1);
            case (next_state_s)
                SNOOP: begin
                    ccwait_r <= ~onehot(next_dgnt_s);
                    ccinv_r  <= ccwrite[next_dgnt_s] ? ~onehot(next_dgnt_s) : {CPUS{1'b0}};
                end
                C2C0, C2C1: begin
                    ccwait_r <= onehot(next_snooper_s);
                    ccinv_r  <= '0;
                end
                default: begin
                    ccwait_r <= '0;
                    ccinv_r  <= '0;
                end
            endcase
        end
    end

    // Handshake waits, load data and RAM address/data decoded from the current state.
    always_comb begin
        dwait       = {CPUS{1'b1}};
        iwait       = {CPUS{1'b1}};
        ramaddr     = '0;
        ramstore    = '0;
        ccsnoopaddr = '0;
        for (int i = 0; i < CPUS; i++) begin
            dload[i*DATA_W +: DATA_W] = ramload;
            iload[i*DATA_W +: DATA_W] = ramload;
        end
        case (state_r)
            SNOOP: begin
                for (int i = 0; i < CPUS; i++) begin
                    if (IDX_W'(i) != dgnt_r) ccsnoopaddr[i*ADDR_W +: ADDR_W] = daddr_a[dgnt_r];
                    else                     ccsnoopaddr[i*ADDR_W +: ADDR_W] = '0;
                end
            end
            RREAD0, RREAD1: begin
                ramaddr = daddr_a[dgnt_r];
                if (access_s && dREN[dgnt_r]) dwait[dgnt_r] = 1'b0;
                else                          dwait[dgnt_r] = 1'b1;
            end
            C2C0, C2C1: begin
                ramaddr  = daddr_a[snooper_r];
                ramstore = dstore_a[snooper_r];
                dload[int'(dgnt_r)*DATA_W +: DATA_W] = dstore_a[snooper_r];
                if (access_s) begin
                    dwait[dgnt_r]    = 1'b0;
                    dwait[snooper_r] = 1'b0;
                end else begin
                    dwait = {CPUS{1'b1}};
                end
            end
            WB0, WB1: begin
                ramaddr  = daddr_a[dgnt_r];
                ramstore = dstore_a[dgnt_r];
                if (access_s && dWEN[dgnt_r]) dwait[dgnt_r] = 1'b0;
                else                          dwait[dgnt_r] = 1'b1;
            end
            IFETCH: begin
                ramaddr = iaddr_a[igrant_r];
                if (access_s && iREN[igrant_r]) iwait[igrant_r] = 1'b0;
                else                            iwait[igrant_r] = 1'b1;
            end
            default: ramaddr = '0;
        endcase
    end
endmodule

// File: tb/tb_coherent_bus_controller.sv
// Directed-vector bench for coherent_bus_controller with two cores.
module tb_coherent_bus_controller;
    localparam int CPUS = 2, AW = 32, DW = 32;
    localparam logic [1:0] FREE = 2'd0, BUSY = 2'd1, ACCESS = 2'd2;

    logic CLK = 1'b0;
    logic nRST;
    logic [CPUS-1:0]    iREN, dREN, dWEN, cctrans, ccwrite;
    logic [CPUS*AW-1:0] iaddr, daddr;
    logic [CPUS*DW-1:0] dstore;
    logic [CPUS-1:0]    iwait, dwait, ccwait, ccinv;
    logic [CPUS*DW-1:0] iload, dload;
    logic [CPUS*AW-1:0] ccsnoopaddr;
    logic               ramREN, ramWEN;
    logic [AW-1:0]      ramaddr;
    logic [DW-1:0]      ramstore, ramload;
    logic [1:0]         ramstate;
    int pass_cnt = 0, tot_cnt = 0;

    always #5 CLK = ~CLK;

    coherent_bus_controller #(.CPUS(CPUS), .ADDR_W(AW), .DATA_W(DW)) dut (
        .CLK(CLK), .nRST(nRST), .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
        .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore), .dwait(dwait), .dload(dload),
        .cctrans(cctrans), .ccwrite(ccwrite), .ccwait(ccwait), .ccinv(ccinv),
        .ccsnoopaddr(ccsnoopaddr), .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr),
        .ramstore(ramstore), .ramload(ramload), .ramstate(ramstate));

    task automatic cyc();
        @(posedge CLK);
        #2;
    endtask

    task automatic clr();
        iREN = '0; dREN = '0; dWEN = '0; cctrans = '0; ccwrite = '0;
        iaddr = '0; daddr = '0; dstore = '0; ramload = '0; ramstate = FREE;
    endtask

    task automatic test_reset();
        nRST = 1'b0;
        clr();
        #3;
        tot_cnt++; if (dwait !== 2'b11) $display("FAIL rst_dwait got %b want 11", dwait); else pass_cnt++;
        tot_cnt++; if (iwait !== 2'b11) $display("FAIL rst_iwait got %b want 11", iwait); else pass_cnt++;
        tot_cnt++; if ({ramREN, ramWEN, ccwait, ccinv} !== 6'b0) $display("FAIL rst_strobes got %b want 0", {ramREN, ramWEN, ccwait, ccinv}); else pass_cnt++;
        tot_cnt++; if (ramaddr !== 32'h0) $display("FAIL rst_ramaddr got %h want 0", ramaddr); else pass_cnt++;
        @(posedge CLK); #2;
        nRST = 1'b1;
        cyc();
    endtask

    task automatic test_read();
        dREN = 2'b01; cctrans = 2'b01; daddr[31:0] = 32'h100;
        #1;
        tot_cnt++; if (dwait !== 2'b11) $display("FAIL rd_grantcycle dwait got %b want 11", dwait); else pass_cnt++;
        cyc(); ramstate = BUSY; #1;
        tot_cnt++; if (ccwait !== 2'b10) $display("FAIL rd_snoop ccwait got %b want 10", ccwait); else pass_cnt++;
        tot_cnt++; if (ccinv !== 2'b00) $display("FAIL rd_snoop ccinv got %b want 00", ccinv); else pass_cnt++;
        tot_cnt++; if (ccsnoopaddr[63:32] !== 32'h100) $display("FAIL rd_snoopaddr got %h want 100", ccsnoopaddr[63:32]); else pass_cnt++;
        cyc(); #1;
        tot_cnt++; if ({ramREN, ramaddr} !== {1'b1, 32'h100}) $display("FAIL rd_w0_ren got %b/%h want 1/100", ramREN, ramaddr); else pass_cnt++;
        tot_cnt++; if ({ccwait, dwait} !== 4'b0011) $display("FAIL rd_busy1 got %b want 0011", {ccwait, dwait}); else pass_cnt++;
        cyc(); #1;
        tot_cnt++; if (dwait !== 2'b11) $display("FAIL rd_busy2 dwait got %b want 11", dwait); else pass_cnt++;
        cyc(); ramstate = ACCESS; ramload = 32'h1111_1111; #1;
        tot_cnt++; if (dwait !== 2'b10) $display("FAIL rd_w0_dwait got %b want 10", dwait); else pass_cnt++;
        tot_cnt++; if (dload[31:0] !== 32'h1111_1111) $display("FAIL rd_w0_dload got %h want 11111111", dload[31:0]); else pass_cnt++;
        cyc(); daddr[31:0] = 32'h104; ramload = 32'h2222_2222; #1;
        tot_cnt++; if ({ramaddr, dwait} !== {32'h104, 2'b10}) $display("FAIL rd_w1 got %h/%b want 104/10", ramaddr, dwait); else pass_cnt++;
        tot_cnt++; if (dload[31:0] !== 32'h2222_2222) $display("FAIL rd_w1_dload got %h want 22222222", dload[31:0]); else pass_cnt++;
        cyc(); clr(); #1;
        tot_cnt++; if ({ramREN, dwait} !== 3'b011) $display("FAIL rd_done got %b want 011", {ramREN, dwait}); else pass_cnt++;
    endtask

    task automatic test_c2c();
        dREN = 2'b10; cctrans = 2'b10; ccwrite = 2'b11;
        daddr = {32'h200, 32'h200}; dstore[31:0] = 32'hDEAD_BEEF;
        cyc(); ramstate = ACCESS; #1;
        tot_cnt++; if ({ccwait, ccinv} !== 4'b0101) $display("FAIL c2c_snoop got %b want 0101", {ccwait, ccinv}); else pass_cnt++;
        cyc(); #1;
        tot_cnt++; if ({ramWEN, ramaddr, ramstore} !== {1'b1, 32'h200, 32'hDEAD_BEEF}) $display("FAIL c2c_w0_ram got %b/%h/%h want 1/200/deadbeef", ramWEN, ramaddr, ramstore); else pass_cnt++;
        tot_cnt++; if (dload[63:32] !== 32'hDEAD_BEEF) $display("FAIL c2c_w0_dload got %h want deadbeef", dload[63:32]); else pass_cnt++;
        tot_cnt++; if ({dwait, ccwait} !== 4'b0001) $display("FAIL c2c_w0_wait got %b want 0001", {dwait, ccwait}); else pass_cnt++;
        cyc(); dstore[31:0] = 32'hCAFE_F00D; daddr = {32'h204, 32'h204}; #1;
        tot_cnt++; if ({ramaddr, dload[63:32], dwait} !== {32'h204, 32'hCAFE_F00D, 2'b00}) $display("FAIL c2c_w1 got %h/%h/%b want 204/cafef00d/00", ramaddr, dload[63:32], dwait); else pass_cnt++;
        cyc(); clr(); #1;
        tot_cnt++; if ({ramWEN, ccwait, dwait} !== 5'b00011) $display("FAIL c2c_done got %b want 00011", {ramWEN, ccwait, dwait}); else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        logic [1:0] exp_dw [12];
        logic [31:0] exp_addr;
        exp_dw = '{2'b11, 2'b10, 2'b10, 2'b11, 2'b01, 2'b01, 2'b11, 2'b10, 2'b10, 2'b11, 2'b01, 2'b01};
        dWEN = 2'b11; daddr = {32'h400, 32'h300}; dstore = {32'hB0, 32'hA0}; ramstate = ACCESS;
        for (int i = 0; i < 12; i++) begin
            if (i != 0) cyc();
            #1;
            exp_addr = (exp_dw[i] == 2'b10) ? 32'h300 : (exp_dw[i] == 2'b01) ? 32'h400 : 32'h0;
            tot_cnt++;
            if ({dwait, ramWEN, ramaddr} !== {exp_dw[i], exp_dw[i] != 2'b11, exp_addr})
                $display("FAIL b2b_%0d got %b/%b/%h want %b/%b/%h", i, dwait, ramWEN, ramaddr, exp_dw[i], exp_dw[i] != 2'b11, exp_addr);
            else pass_cnt++;
        end
        cyc(); clr();
    endtask

    task automatic test_priority();
        iREN = 2'b01; iaddr[31:0] = 32'h500; dREN = 2'b10; cctrans = 2'b10;
        daddr[63:32] = 32'h600; ramstate = ACCESS; ramload = 32'h33;
        cyc(); #1;
        tot_cnt++; if ({ccwait, iwait} !== 4'b0111) $display("FAIL pri_snoop got %b want 0111", {ccwait, iwait}); else pass_cnt++;
        cyc(); #1;
        tot_cnt++; if ({dwait, iwait, ramaddr} !== {4'b0111, 32'h600}) $display("FAIL pri_rd0 got %b/%b/%h want 01/11/600", dwait, iwait, ramaddr); else pass_cnt++;
        cyc(); #1;
        tot_cnt++; if ({dwait, iwait} !== 4'b0111) $display("FAIL pri_rd1 got %b want 0111", {dwait, iwait}); else pass_cnt++;
        cyc(); dREN = 2'b00; cctrans = 2'b00; #1;
        tot_cnt++; if (iwait !== 2'b11) $display("FAIL pri_idle iwait got %b want 11", iwait); else pass_cnt++;
        cyc(); #1;
        tot_cnt++; if ({iwait, ramREN, ramaddr, iload[31:0]} !== {2'b10, 1'b1, 32'h500, 32'h33}) $display("FAIL pri_ifetch got %b/%b/%h/%h want 10/1/500/33", iwait, ramREN, ramaddr, iload[31:0]); else pass_cnt++;
        cyc(); clr(); #1;
        tot_cnt++; if ({iwait, ramREN} !== 3'b110) $display("FAIL pri_done got %b want 110", {iwait, ramREN}); else pass_cnt++;
    endtask

    task automatic test_upgrade();
        cctrans = 2'b01; ccwrite = 2'b01; daddr[31:0] = 32'h700;
        cyc(); #1;
        tot_cnt++; if ({ccinv, ccwait, ramREN, ramWEN} !== 6'b101000) $display("FAIL upg_snoop got %b want 101000", {ccinv, ccwait, ramREN, ramWEN}); else pass_cnt++;
        cyc(); clr(); #1;
        tot_cnt++; if ({ccinv, ccwait, ramREN, ramWEN, dwait} !== 8'b00000011) $display("FAIL upg_idle got %b want 00000011", {ccinv, ccwait, ramREN, ramWEN, dwait}); else pass_cnt++;
    endtask

    task automatic test_drop();
        dWEN = 2'b10; daddr = {32'hA00, 32'h900}; ramstate = BUSY;
        cyc(); dWEN = 2'b00; ramstate = ACCESS; #1;
        tot_cnt++; if ({ramWEN, dwait} !== 3'b111) $display("FAIL drop_wb0 got %b want 111", {ramWEN, dwait}); else pass_cnt++;
        cyc(); dWEN = 2'b11; ramstate = FREE; #1;
        tot_cnt++; if ({ramWEN, dwait} !== 3'b011) $display("FAIL drop_idle got %b want 011", {ramWEN, dwait}); else pass_cnt++;
        cyc(); #1;
        tot_cnt++; if (ramaddr !== 32'hA00) $display("FAIL drop_rr got %h want a00", ramaddr); else pass_cnt++;
        dWEN = 2'b00;
        cyc(); clr();
    endtask

    task automatic test_midreset();
        dREN = 2'b01; cctrans = 2'b01; daddr[31:0] = 32'h800; ramstate = ACCESS;
        cyc(); cyc(); cyc(); #1;
        nRST = 1'b0; #1;
        tot_cnt++; if ({ramREN, dwait, iwait} !== 5'b01111) $display("FAIL mrst_now got %b want 01111", {ramREN, dwait, iwait}); else pass_cnt++;
        clr(); dREN = 2'b11; cctrans = 2'b11; daddr = {32'h900, 32'h800};
        nRST = 1'b1;
        cyc(); #1;
        tot_cnt++; if ({ccwait, ccsnoopaddr[63:32]} !== {2'b10, 32'h800}) $display("FAIL mrst_core0_first got %b/%h want 10/800", ccwait, ccsnoopaddr[63:32]); else pass_cnt++;
        nRST = 1'b0; #1;
        dREN = 2'b10; cctrans = 2'b10;
        nRST = 1'b1;
        cyc(); #1;
        tot_cnt++; if (ccwait !== 2'b01) $display("FAIL mrst_core1 got %b want 01", ccwait); else pass_cnt++;
        nRST = 1'b0;
        clr();
    endtask

    initial begin
        test_reset();
        test_read();
        test_c2c();
        test_back_to_back();
        test_priority();
        test_upgrade();
        test_drop();
        test_midreset();
        $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end
endmodule
